adc_miso_collector: RTL and testbench

- Receive-side counterpart of the SPI master byte sequencer.
- Collects MISO bytes returned by the SPI master core during an LTC2494 ADC frame and assembles them into the 24-bit conversion word.
- Decodes the word into a signed result with range flags, checks framing, and hands the result to the data driver with a one-cycle valid pulse.
- Sits between the SPI master core (byte interface) and the data driver; observes the ADC chip select to delimit frames.

---
 rtl/adc_miso_collector.sv | 144 ++++++++++++++
 tb/tb_adc_miso_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_miso_collector.sv
// Collects LTC2494 MISO bytes within a chip-select window, validates the frame,
// and publishes the offset-binary conversion as a signed result with range flags.
module adc_miso_collector #(
   parameter int BYTES_PER_FRAME = 3,
   parameter int RESULT_W        = 17,
   parameter int CH_W            = 5
) (
   input  logic                i_FPGA_clk,
   input  logic                i_FPGA_rst,
   input  logic                i_CS,
   input  logic [7:0]          i_MISO_byte,
   input  logic                i_MISO_dv,
   input  logic [CH_W-1:0]     i_channel,
   output logic [23:0]         o_ADC_raw,
   output logic [RESULT_W-1:0] o_result,
   output logic [CH_W-1:0]     o_channel,
   output logic                o_overrange,
   output logic                o_underrange,
   output logic                o_DataValid,
   output logic                o_error,
   output logic                o_busy
);

   localparam int CNT_W = $clog2(BYTES_PER_FRAME + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_FRAME);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BYTES_PER_FRAME + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK} state_t;

   state_t                state_q, state_d;
   logic                  cs_q, cs_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [23:0]           shift_q, shift_d;
   logic                  ovf_q, ovf_d;
   logic [CH_W-1:0]       tag_q, tag_d;
   logic [23:0]           raw_q, raw_d;
   logic [RESULT_W-1:0]   result_q, result_d;
   logic [CH_W-1:0]       chan_q, chan_d;
   logic                  over_q, over_d;
   logic                  under_q, under_d;
   logic                  dv_q, dv_d;
   logic                  err_q, err_d;

   logic cs_fall, cs_rise, frame_ok;

   assign cs_fall  = cs_q & ~i_CS;
   assign cs_rise  = ~cs_q & i_CS;
   assign frame_ok = (cnt_q == CNT_FULL) && !ovf_q && (shift_q[23:22] == 2'b00);

   always_comb begin
      state_d  = state_q;
      cs_d     = i_CS;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      ovf_d    = ovf_q;
      tag_d    = tag_q;
      raw_d    = raw_q;
      result_d = result_q;
      chan_d   = chan_q;
      over_d   = over_q;
      under_d  = under_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: ;
         S_COLLECT: begin
            // A byte landing on the closing edge still belongs to this frame.
            if (i_MISO_dv) begin
               if (cnt_q < CNT_FULL) shift_d = {shift_q[15:0], i_MISO_byte};
               else                  ovf_d   = 1'b1;
               if (cnt_q < CNT_SAT)  cnt_d   = cnt_q + 1'b1;
            end
            if (cs_rise) state_d = (cnt_d == '0) ? S_IDLE : S_CHECK;
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (frame_ok) begin
               raw_d    = shift_q;
               // Offset binary to two's complement: flip the SIG bit.
               result_d = RESULT_W'({~shift_q[21], shift_q[20:5]});
               over_d   = shift_q[21] & shift_q[20];
               under_d  = ~shift_q[21] & ~shift_q[20];
               chan_d   = tag_q;
               dv_d     = 1'b1;
            end else begin
               err_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cs_fall && state_q != S_COLLECT) begin
         state_d = S_COLLECT;
         tag_d   = i_channel;
         shift_d = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
      if (i_FPGA_rst) begin
         state_q  <= S_IDLE;
         // Cleared low so a CS still low at reset release cannot fake a start edge.
         cs_q     <= 1'b0;
         cnt_q    <= '0;
         shift_q  <= '0;
         ovf_q    <= 1'b0;
         tag_q    <= '0;
         raw_q    <= '0;
         result_q <= '0;
         chan_q   <= '0;
         over_q   <= 1'b0;
         under_q  <= 1'b0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cs_q     <= cs_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         ovf_q    <= ovf_d;
         tag_q    <= tag_d;
         raw_q    <= raw_d;
         result_q <= result_d;
         chan_q   <= chan_d;
         over_q   <= over_d;
         under_q  <= under_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
      end
   end

   assign o_ADC_raw    = raw_q;
   assign o_result     = result_q;
   assign o_channel    = chan_q;
   assign o_overrange  = over_q;
   assign o_underrange = under_q;
   assign o_DataValid  = dv_q;
   assign o_error      = err_q;
   assign o_busy       = (state_q == S_COLLECT);

endmodule

// File: tb/tb_adc_miso_collector.sv
// Directed bench for adc_miso_collector: valid, rejected, back-to-back and reset-abort frames.
module tb_adc_miso_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic [7:0]  mbyte;
   logic        mdv;
   logic [4:0]  chan_in;
   logic [23:0] raw;
   logic [16:0] result;
   logic [4:0]  chan_out;
   logic        over, under, dv, err, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int dv_cnt   = 0;
   int err_cnt  = 0;
   int dv_cyc   = -1;
   int both_cnt = 0;
   int cs_cyc   = 0;

   adc_miso_collector dut (
      .i_FPGA_clk   (clk),
      .i_FPGA_rst   (rst),
      .i_CS         (cs),
      .i_MISO_byte  (mbyte),
      .i_MISO_dv    (mdv),
      .i_channel    (chan_in),
      .o_ADC_raw    (raw),
      .o_result     (result),
      .o_channel    (chan_out),
      .o_overrange  (over),
      .o_underrange (under),
      .o_DataValid  (dv),
      .o_error      (err),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv) begin dv_cnt++; dv_cyc = cyc; end
      if (err) err_cnt++;
      if (dv && err) both_cnt++;
   end

   task automatic clr_mon();
      dv_cnt = 0; err_cnt = 0; dv_cyc = -1;
   endtask

   task automatic put_byte(input logic [7:0] b);
      @(negedge clk); mdv = 1'b1; mbyte = b;
      @(negedge clk); mdv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Opens a frame, sends n bytes, closes it and lets the result settle.
   task automatic run_frame(input logic [4:0] ch, input int n,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] bs [4];
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      @(negedge clk); cs = 1'b0; chan_in = ch;
      repeat (2) @(negedge clk);
      chan_in = ~ch;
      for (int i = 0; i < n; i++) put_byte(bs[i]);
      @(negedge clk); cs = 1'b1; cs_cyc = cyc;
      repeat (5) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cs = 1'b1; mbyte = '0; mdv = 1'b0; chan_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({raw, result, chan_out, over, under, dv, err, busy} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got raw=%h res=%h ch=%0d flags=%b want all 0",
                            raw, result, chan_out, {over, under, dv, err, busy});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_valid_over();
      clr_mon();
      @(negedge clk); cs = 1'b0; chan_in = 5'd5;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b want 1", busy); end
      chan_in = 5'd0;
      put_byte(8'h30); put_byte(8'h12); put_byte(8'h34);
      @(negedge clk); cs = 1'b1; cs_cyc = cyc;
      repeat (5) @(negedge clk); #1;
      n_checks++;
      if (raw !== 24'h301234) begin n_fail++; $display("FAIL f1_raw: got %h want 301234", raw); end
      n_checks++;
      if (result !== 17'h08091) begin n_fail++; $display("FAIL f1_result: got %h want 08091", result); end
      n_checks++;
      if ({over, under} !== 2'b10) begin n_fail++; $display("FAIL f1_range: got %b want 10", {over, under}); end
      n_checks++;
      if (chan_out !== 5'd5) begin n_fail++; $display("FAIL f1_channel: got %0d want 5", chan_out); end
      n_checks++;
      if (dv_cnt !== 1 || err_cnt !== 0) begin
         n_fail++; $display("FAIL f1_pulses: got dv=%0d err=%0d want 1/0", dv_cnt, err_cnt);
      end
      n_checks++;
      if (dv_cyc !== cs_cyc + 2) begin
         n_fail++; $display("FAIL f1_latency: got cycle %0d want %0d", dv_cyc, cs_cyc + 2);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b want 0", busy); end
   endtask

   task automatic test_valid_under();
      clr_mon();
      run_frame(5'd9, 3, 8'h0F, 8'hFF, 8'hE0, 8'h00);
      n_checks++;
      if (raw !== 24'h0FFFE0 || result !== 17'h17FFF) begin
         n_fail++; $display("FAIL f2_data: got raw=%h res=%h want 0fffe0/17fff", raw, result);
      end
      n_checks++;
      if ({over, under} !== 2'b01 || chan_out !== 5'd9) begin
         n_fail++; $display("FAIL f2_flags: got range=%b ch=%0d want 01/9", {over, under}, chan_out);
      end
      n_checks++;
      if (dv_cnt !== 1 || err_cnt !== 0) begin
         n_fail++; $display("FAIL f2_pulses: got dv=%0d err=%0d want 1/0", dv_cnt, err_cnt);
      end
   endtask

   task automatic test_errors();
      clr_mon();
      run_frame(5'd3, 3, 8'h80, 8'h00, 8'h00, 8'h00);
      n_checks++;
      if (dv_cnt !== 0 || err_cnt !== 1) begin
         n_fail++; $display("FAIL eoc_pulses: got dv=%0d err=%0d want 0/1", dv_cnt, err_cnt);
      end
      n_checks++;
      if (raw !== 24'h0FFFE0 || result !== 17'h17FFF || chan_out !== 5'd9 || {over, under} !== 2'b01) begin
         n_fail++; $display("FAIL eoc_hold: got raw=%h res=%h ch=%0d want 0fffe0/17fff/9", raw, result, chan_out);
      end
      clr_mon();
      run_frame(5'd1, 4, 8'h01, 8'h02, 8'h03, 8'h04);
      n_checks++;
      if (dv_cnt !== 0 || err_cnt !== 1) begin
         n_fail++; $display("FAIL four_bytes: got dv=%0d err=%0d want 0/1", dv_cnt, err_cnt);
      end
      clr_mon();
      run_frame(5'd1, 2, 8'h01, 8'h02, 8'h00, 8'h00);
      n_checks++;
      if (dv_cnt !== 0 || err_cnt !== 1) begin
         n_fail++; $display("FAIL two_bytes: got dv=%0d err=%0d want 0/1", dv_cnt, err_cnt);
      end
      clr_mon();
      run_frame(5'd1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      n_checks++;
      if (dv_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL empty_frame: got dv=%0d err=%0d busy=%b want 0/0/0", dv_cnt, err_cnt, busy);
      end
      n_checks++;
      if (raw !== 24'h0FFFE0) begin n_fail++; $display("FAIL err_raw_hold: got %h want 0fffe0", raw); end
   endtask

   task automatic test_back_to_back();
      clr_mon();
      @(negedge clk); cs = 1'b0; chan_in = 5'd7;
      repeat (2) @(negedge clk);
      chan_in = 5'd0;
      put_byte(8'h3A); put_byte(8'hBC); put_byte(8'hDE);
      @(negedge clk); cs = 1'b1;
      @(negedge clk); cs = 1'b0; chan_in = 5'd12;
      @(negedge clk); #1;
      n_checks++;
      if (dv !== 1'b1 || raw !== 24'h3ABCDE || result !== 17'h0D5E6 || chan_out !== 5'd7 || over !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first: got dv=%b raw=%h res=%h ch=%0d ov=%b want 1/3abcde/0d5e6/7/1",
                            dv, raw, result, chan_out, over);
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
      chan_in = 5'd0;
      put_byte(8'h25); put_byte(8'h55); put_byte(8'h40);
      @(negedge clk); cs = 1'b1;
      repeat (5) @(negedge clk); #1;
      n_checks++;
      if (raw !== 24'h255540 || result !== 17'h02AAA || chan_out !== 5'd12 || {over, under} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_second: got raw=%h res=%h ch=%0d range=%b want 255540/02aaa/12/00",
                            raw, result, chan_out, {over, under});
      end
      n_checks++;
      if (dv_cnt !== 2 || err_cnt !== 0) begin
         n_fail++; $display("FAIL b2b_pulses: got dv=%0d err=%0d want 2/0", dv_cnt, err_cnt);
      end
   endtask

   task automatic test_reset_abort();
      @(negedge clk); cs = 1'b0; chan_in = 5'd2;
      repeat (2) @(negedge clk);
      put_byte(8'h11); put_byte(8'h22);
      rst = 1'b1; #1;
      n_checks++;
      if ({raw, result, chan_out, over, under, dv, err, busy} !== '0) begin
         n_fail++; $display("FAIL abort_clear: got raw=%h res=%h busy=%b want 0", raw, result, busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clr_mon();
      put_byte(8'h33);
      @(negedge clk); cs = 1'b1;
      repeat (5) @(negedge clk); #1;
      n_checks++;
      if (dv_cnt !== 0 || err_cnt !== 0) begin
         n_fail++; $display("FAIL abort_silent: got dv=%0d err=%0d want 0/0", dv_cnt, err_cnt);
      end
      clr_mon();
      run_frame(5'd4, 3, 8'h12, 8'h34, 8'h56, 8'h00);
      n_checks++;
      if (dv_cnt !== 1 || err_cnt !== 0 || raw !== 24'h123456 || result !== 17'h191A2 || chan_out !== 5'd4) begin
         n_fail++; $display("FAIL after_abort: got dv=%0d err=%0d raw=%h res=%h ch=%0d want 1/0/123456/191a2/4",
                            dv_cnt, err_cnt, raw, result, chan_out);
      end
   endtask

   initial begin
      test_reset();
      test_valid_over();
      test_valid_under();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      n_checks++;
      if (both_cnt !== 0) begin n_fail++; $display("FAIL dv_err_overlap: got %0d want 0", both_cnt); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
